// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/external arbiter for the single-port data RAM, one 3-cycle transaction at a time
// The CPU has priority; a streak counter forces an external grant after MAX_CPU_STREAK contested CPU grants.
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_next;
  logic              owner_ext;
  logic              we_q;
  logic [SW-1:0]     streak;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              grant_ext;
  logic              grant_cpu;

  assign grant_ext = ext_req && (!cpu_req || streak == STREAK_MAX);
  assign grant_cpu = cpu_req && !grant_ext;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ext || grant_cpu) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_ext   <= 1'b0;
      we_q        <= 1'b0;
      streak      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (grant_ext) begin
          owner_ext <= 1'b1;
          we_q      <= ext_we;
          mem_addr  <= ext_addr;
          mem_wdata <= ext_wdata;
          streak    <= '0;
        end else if (grant_cpu) begin
          owner_ext <= 1'b0;
          we_q      <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
          // Only grants that make a waiting external requester wait again count.
          if (!ext_req)
            streak <= '0;
          else if (streak != STREAK_MAX)
            streak <= streak + SW'(1);
        end
      end
      // Read data is captured as the response completes so it holds until the owner's next read.
      if (state == RESP && !we_q) begin
        if (owner_ext) ext_rdata_q <= mem_rdata;
        else           cpu_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign cpu_done  = (state == RESP) && !owner_ext;
  assign ext_ack   = (state == RESP) && owner_ext;
  assign cpu_rdata = (cpu_done && !we_q) ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = (ext_ack && !we_q) ? mem_rdata : ext_rdata_q;
  assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with a synchronous RAM model
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] ram [0:255];

  int checks = 0;
  int errors = 0;
  int done_cnt;
  int we_cnt;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_CPU_STREAK(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_addr [0:5];
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 16'hBEEF;
    tick();
    pre_en = 1'b0;
    tick();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'({cpu_done, ext_ack}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ext_rdata", 32'(ext_rdata), 32'd0);
    chk("rst_stall_follows_req", 32'(cpu_stall), 32'd1);
    chk("rst_streak", 32'(dut.streak), 32'd0);
    cpu_req = 1'b0;
    rst = 1'b0;
    tick();

    // CPU read of 0x0010
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("rd_c0_stall", 32'(cpu_stall), 32'd1);
    tick();
    chk("rd_c1_mem_en", 32'(mem_en), 32'd1);
    chk("rd_c1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd_c1_stall", 32'(cpu_stall), 32'd1);
    tick();
    chk("rd_c2_done", 32'(cpu_done), 32'd1);
    chk("rd_c2_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("rd_c2_stall", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    tick();

    // EXT write 0x1234 to 0x0020, then CPU read of it
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0020; ext_wdata = 16'h1234;
    tick();
    chk("ew_c1_mem_we", 32'(mem_we), 32'd1);
    tick();
    chk("ew_c2_ack", 32'(ext_ack), 32'd1);
    ext_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    tick();
    tick();
    chk("ew_c5_cpu_done", 32'(cpu_done), 32'd1);
    chk("ew_c5_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    chk("ew_c5_ext_rdata_kept", 32'(ext_rdata), 32'h0000);
    cpu_req = 1'b0;
    tick();
    chk("ew_cpu_rdata_held", 32'(cpu_rdata), 32'h1234);

    // Simultaneous requests: CPU reads 0x0020, EXT reads 0x0010
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0010;
    tick();
    chk("sim_c1_mem_en", 32'(mem_en), 32'd1);
    chk("sim_c1_mem_addr", 32'(mem_addr), 32'h0020);
    tick();
    chk("sim_c2_cpu_done", 32'(cpu_done), 32'd1);
    chk("sim_c2_ext_ack", 32'(ext_ack), 32'd0);
    chk("sim_c2_mem_en", 32'(mem_en), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("sim_c3_mem_en", 32'(mem_en), 32'd0);
    tick();
    chk("sim_c4_mem_en", 32'(mem_en), 32'd1);
    chk("sim_c4_mem_addr", 32'(mem_addr), 32'h0010);
    tick();
    chk("sim_c5_ext_ack", 32'(ext_ack), 32'd1);
    chk("sim_c5_ext_rdata", 32'(ext_rdata), 32'hBEEF);
    ext_req = 1'b0;
    tick();

    // Starvation with MAX_CPU_STREAK=2: grants C C E C C E
    exp_addr[0] = 16'h0030; exp_addr[1] = 16'h0030; exp_addr[2] = 16'h0040;
    exp_addr[3] = 16'h0030; exp_addr[4] = 16'h0030; exp_addr[5] = 16'h0040;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0040;
    for (int t = 0; t < 18; t++) begin
      #1;
      if (t % 3 == 1) begin
        chk($sformatf("starve_c%0d_mem_en", t), 32'(mem_en), 32'd1);
        chk($sformatf("starve_c%0d_owner_addr", t), 32'(mem_addr), 32'(exp_addr[t / 3]));
      end
      if (t >= 6 && t <= 11)
        chk($sformatf("starve_c%0d_stall", t), 32'(cpu_stall), (t <= 10) ? 32'd1 : 32'd0);
      tick();
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
    tick();
    chk("starve_end_streak", 32'(dut.streak), 32'd0);

    // Back-to-back CPU writes with ext_req low
    done_cnt = 0;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'(i); cpu_wdata = 16'hA000 + 16'(i);
      if (mem_we) we_cnt++;
      tick();
      if (mem_we) we_cnt++;
      chk($sformatf("wr%0d_mem_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("wr%0d_mem_addr", i), 32'(mem_addr), 32'(i));
      chk($sformatf("wr%0d_mem_wdata", i), 32'(mem_wdata), 32'hA000 + 32'(i));
      tick();
      if (mem_we) we_cnt++;
      if (cpu_done) done_cnt++;
      tick();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_done_count", 32'(done_cnt), 32'd4);
    chk("wr_we_count", 32'(we_cnt), 32'd4);
    chk("wr_streak", 32'(dut.streak), 32'd0);
    chk("wr_ram_2", 32'(ram[2]), 32'hA002);
    tick();

    // Reset during ISSUE of an EXT read
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0010;
    tick();
    chk("rm_issue_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    tick();
    chk("rm_mem_en", 32'(mem_en), 32'd0);
    chk("rm_no_ack", 32'(ext_ack), 32'd0);
    chk("rm_state_idle", 32'(dut.state), 32'd0);
    chk("rm_streak", 32'(dut.streak), 32'd0);
    rst = 1'b0;
    tick();
    chk("rm_reaccept_mem_en", 32'(mem_en), 32'd1);
    chk("rm_reaccept_addr", 32'(mem_addr), 32'h0010);
    tick();
    chk("rm_ack", 32'(ext_ack), 32'd1);
    chk("rm_ext_rdata", 32'(ext_rdata), 32'hBEEF);
    ext_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
